dl_ram_arbiter: RTL and testbench

//  Downstream stage of the SPI download controller: buffers its byte writes (wr/a/d) in a small FIFO
//  and merges them with CPU accesses onto one fixed-latency external RAM port. Download writes

---
 rtl/dl_ram_arbiter_if.sv | 37 +++
 rtl/dl_ram_arbiter.sv | 129 ++++++++++++
 tb/tb_dl_ram_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dl_ram_arbiter_if.sv
// Bus bundle between the download/CPU side and the arbiter, plus the external RAM port.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface dl_ram_arbiter_if #(
   parameter int AW = 25
);
   logic          downloading;
   logic          dl_wr;
   logic [AW-1:0] dl_addr;
   logic [7:0]    dl_data;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_din;
   logic [7:0]    cpu_dout;
   logic          cpu_ack;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_dout;
   logic [7:0]    ram_din;
   logic          ram_we;
   logic          ram_oe;
   logic          dl_busy;
   logic          dl_overflow;

   modport slave (
      input  downloading, dl_wr, dl_addr, dl_data,
      input  cpu_req, cpu_we, cpu_addr, cpu_din, ram_din,
      output cpu_dout, cpu_ack, ram_addr, ram_dout, ram_we, ram_oe,
      output dl_busy, dl_overflow
   );

   modport master (
      output downloading, dl_wr, dl_addr, dl_data,
      output cpu_req, cpu_we, cpu_addr, cpu_din, ram_din,
      input  cpu_dout, cpu_ack, ram_addr, ram_dout, ram_we, ram_oe,
      input  dl_busy, dl_overflow
   );
endinterface

// File: rtl/dl_ram_arbiter.sv
// Buffers download byte writes in a small FIFO and merges them with CPU accesses onto
// one fixed-latency RAM port; queued download writes always win over the CPU.
module dl_ram_arbiter #(
   parameter int AW            = 25,
   parameter int FIFO_DEPTH    = 4,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   dl_ram_arbiter_if.slave  bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [PW:0]   LVL_FULL = (PW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

   // IDLE: choose next access | DLW: download write on RAM | CPU: CPU access on RAM
   typedef enum logic [1:0] {IDLE, DLW, CPU} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [AW+7:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   level_q, level_d;
   logic          overflow_q, downloading_q;
   logic [AW-1:0] ram_addr_q;
   logic [7:0]    ram_dout_q, cpu_dout_q;
   logic          ram_we_q, ram_oe_q, cpu_ack_q;
   logic          full, empty, push, pop;
   logic [AW+7:0] head;

   assign full  = (level_q == LVL_FULL);
   assign empty = (level_q == '0);
   assign push  = bus.dl_wr && !full;
   assign pop   = (state_q == IDLE) && !empty;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      level_d = level_q;
      if (push && !pop)
         level_d = level_q + (PW+1)'(1);
      else if (pop && !push)
         level_d = level_q - (PW+1)'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         overflow_q    <= 1'b0;
         downloading_q <= 1'b0;
      end else begin
         downloading_q <= bus.downloading;
         level_q       <= level_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + PW'(1);
         if (bus.dl_wr && full)
            overflow_q <= 1'b1;
         else if (bus.downloading && !downloading_q)
            overflow_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= {bus.dl_addr, bus.dl_data};
   end

   // A dl_wr arriving this very edge defers the CPU so the download keeps strict priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ram_addr_q <= '0;
         ram_dout_q <= '0;
         ram_we_q   <= 1'b0;
         ram_oe_q   <= 1'b0;
         cpu_ack_q  <= 1'b0;
         cpu_dout_q <= '0;
      end else begin
         cpu_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!empty) begin
                  state_q    <= DLW;
                  ram_addr_q <= head[AW+7:8];
                  ram_dout_q <= head[7:0];
                  ram_we_q   <= 1'b1;
                  cnt_q      <= CNT_LOAD;
               end else if (bus.cpu_req && !cpu_ack_q && !bus.dl_wr) begin
                  state_q    <= CPU;
                  ram_addr_q <= bus.cpu_addr;
                  ram_dout_q <= bus.cpu_din;
                  ram_we_q   <= bus.cpu_we;
                  ram_oe_q   <= !bus.cpu_we;
                  cnt_q      <= CNT_LOAD;
               end
            end
            DLW, CPU: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  ram_we_q <= 1'b0;
                  ram_oe_q <= 1'b0;
                  state_q  <= IDLE;
                  if (state_q == CPU) begin
                     cpu_ack_q <= 1'b1;
                     if (ram_oe_q)
                        cpu_dout_q <= bus.ram_din;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_dout    = ram_dout_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_oe      = ram_oe_q;
   assign bus.cpu_ack     = cpu_ack_q;
   assign bus.cpu_dout    = cpu_dout_q;
   assign bus.dl_overflow = overflow_q;
   assign bus.dl_busy     = bus.downloading || !empty || (state_q == DLW);
endmodule

// File: tb/tb_dl_ram_arbiter.sv
// Directed bench for dl_ram_arbiter: expected RAM accesses and CPU read data are queued as
// stimulus is issued; a negedge monitor pops and compares whenever a strobe or ack appears.
module tb_dl_ram_arbiter;
   localparam int AW = 25;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } acc_t;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   acc_t       exp_q[$];
   logic [7:0] ack_q[$];

   dl_ram_arbiter_if #(.AW(AW)) bus ();

   dl_ram_arbiter #(.AW(AW), .FIFO_DEPTH(4), .ACCESS_CYCLES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!bus.dl_busy && !bus.ram_we && !bus.ram_oe && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_reached", 32'(ok), 32'd1);
   endtask

   task automatic cpu_wait_ack(output int n);
      bit got = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n++;
         if (bus.cpu_ack) begin
            got = 1'b1;
            break;
         end
      end
      chk("ack_seen", 32'(got), 32'd1);
   endtask

   task automatic dl_set(input logic [AW-1:0] a, input logic [7:0] d, input bit expect_it);
      bus.dl_wr   = 1'b1;
      bus.dl_addr = a;
      bus.dl_data = d;
      if (expect_it)
         exp_q.push_back('{we: 1'b1, addr: a, data: d});
   endtask

   task automatic cpu_set(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = we;
      bus.cpu_addr = a;
      bus.cpu_din  = d;
      exp_q.push_back('{we: we, addr: a, data: d});
   endtask

   // Monitor
   bit            prev_strobe = 1'b0;
   bit            prev_ack    = 1'b0;
   int            run_len     = 0;
   logic [AW-1:0] cur_addr;
   acc_t          e;

   always @(negedge clk) begin
      if (reset) begin
         prev_strobe = 1'b0;
         prev_ack    = 1'b0;
         run_len     = 0;
      end else begin
         if ((bus.ram_we || bus.ram_oe) && !prev_strobe) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_access: addr %h we %b oe %b, none expected",
                        bus.ram_addr, bus.ram_we, bus.ram_oe);
            end else begin
               e = exp_q.pop_front();
               chk("acc_we", 32'(bus.ram_we), 32'(e.we));
               chk("acc_oe", 32'(bus.ram_oe), 32'(!e.we));
               chk("acc_addr", 32'(bus.ram_addr), 32'(e.addr));
               if (e.we)
                  chk("acc_dout", 32'(bus.ram_dout), 32'(e.data));
            end
            cur_addr = bus.ram_addr;
            run_len  = 1;
         end else if (bus.ram_we || bus.ram_oe) begin
            run_len++;
            chk("addr_stable", 32'(bus.ram_addr), 32'(cur_addr));
         end else if (prev_strobe) begin
            chk("strobe_len", 32'(run_len), 32'd2);
         end
         if (bus.cpu_ack) begin
            chk("ack_width", 32'(prev_ack), 32'd0);
            if (ack_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: dout %h, none expected", bus.cpu_dout);
            end else begin
               chk("cpu_dout", 32'(bus.cpu_dout), 32'(ack_q.pop_front()));
            end
         end
         prev_strobe = bus.ram_we || bus.ram_oe;
         prev_ack    = bus.cpu_ack;
      end
   end

   initial begin
      int n;
      reset           = 1'b1;
      bus.downloading = 1'b0;
      bus.dl_wr       = 1'b0;
      bus.dl_addr     = '0;
      bus.dl_data     = '0;
      bus.cpu_req     = 1'b0;
      bus.cpu_we      = 1'b0;
      bus.cpu_addr    = '0;
      bus.cpu_din     = '0;
      bus.ram_din     = '0;
      tick();
      tick();
      chk("rst_we", 32'(bus.ram_we), 32'd0);
      chk("rst_oe", 32'(bus.ram_oe), 32'd0);
      chk("rst_ack", 32'(bus.cpu_ack), 32'd0);
      chk("rst_busy", 32'(bus.dl_busy), 32'd0);
      chk("rst_ovf", 32'(bus.dl_overflow), 32'd0);
      chk("rst_addr", 32'(bus.ram_addr), 32'd0);
      reset = 1'b0;
      tick();

      // 1: single download write, exact latency
      dl_set(25'h010000, 8'hA5, 1'b1);
      tick();
      bus.dl_wr = 1'b0;
      chk("t1_we_k", 32'(bus.ram_we), 32'd0);
      tick();
      chk("t1_we_k1", 32'(bus.ram_we), 32'd1);
      chk("t1_addr", 32'(bus.ram_addr), 32'h010000);
      chk("t1_dout", 32'(bus.ram_dout), 32'hA5);
      chk("t1_busy", 32'(bus.dl_busy), 32'd1);
      tick();
      chk("t1_we_k2", 32'(bus.ram_we), 32'd1);
      tick();
      chk("t1_we_k3", 32'(bus.ram_we), 32'd0);
      chk("t1_busy_end", 32'(bus.dl_busy), 32'd0);
      chk("t1_addr_hold", 32'(bus.ram_addr), 32'h010000);
      tick();

      // 2: burst of four
      bus.downloading = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         dl_set(AW'(i), 8'(8'h10 + i), 1'b1);
         tick();
      end
      bus.dl_wr = 1'b0;
      chk("t2_ovf", 32'(bus.dl_overflow), 32'd0);
      bus.downloading = 1'b0;
      #1;
      chk("t2_busy_queued", 32'(bus.dl_busy), 32'd1);
      wait_idle();

      // 3: fill the FIFO; with depth 4 and 3-cycle drain the 7th back-to-back write is dropped
      for (int i = 0; i < 7; i++) begin
         dl_set(AW'(25'h100 + i), 8'(8'h20 + i), i < 6);
         tick();
         if (i == 5)
            chk("t3_ovf_before", 32'(bus.dl_overflow), 32'd0);
      end
      bus.dl_wr = 1'b0;
      chk("t3_ovf_set", 32'(bus.dl_overflow), 32'd1);
      wait_idle();
      chk("t3_ovf_sticky", 32'(bus.dl_overflow), 32'd1);
      bus.downloading = 1'b1;
      tick();
      chk("t3_ovf_clear", 32'(bus.dl_overflow), 32'd0);
      bus.downloading = 1'b0;
      tick();

      // 4: CPU read, req held through ack; then CPU write
      bus.ram_din = 8'h5A;
      cpu_set(1'b0, 25'h1234, 8'h00);
      ack_q.push_back(8'h5A);
      cpu_wait_ack(n);
      chk("t4_ack_latency", 32'(n), 32'd3);
      tick();
      chk("t4_ack_low", 32'(bus.cpu_ack), 32'd0);
      bus.cpu_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_no_second", 32'(bus.ram_oe), 32'd0);
      end
      cpu_set(1'b1, 25'h2222, 8'h77);
      ack_q.push_back(8'h5A);
      cpu_wait_ack(n);
      bus.cpu_req = 1'b0;
      wait_idle();

      // 5a: simultaneous cpu_req and dl_wr -> download first
      bus.ram_din = 8'hC3;
      dl_set(25'h0400, 8'h99, 1'b1);
      cpu_set(1'b0, 25'h0300, 8'h00);
      ack_q.push_back(8'hC3);
      tick();
      bus.dl_wr = 1'b0;
      cpu_wait_ack(n);
      chk("t5a_ack_latency", 32'(n), 32'd6);
      bus.cpu_req = 1'b0;
      wait_idle();

      // 5b: dl_wr during a CPU access -> CPU finishes first
      bus.ram_din = 8'h3C;
      cpu_set(1'b0, 25'h0500, 8'h00);
      ack_q.push_back(8'h3C);
      tick();
      dl_set(25'h0600, 8'h42, 1'b1);
      tick();
      bus.dl_wr = 1'b0;
      cpu_wait_ack(n);
      bus.cpu_req = 1'b0;
      wait_idle();

      // 6: reset mid-DLW with two entries queued
      for (int i = 0; i < 3; i++) begin
         dl_set(AW'(25'h0700 + i), 8'(8'h50 + i), 1'b1);
         tick();
      end
      bus.dl_wr = 1'b0;
      chk("t6_mid_dlw", 32'(bus.ram_we), 32'd1);
      reset = 1'b1;
      #1;
      chk("t6_we_drop", 32'(bus.ram_we), 32'd0);
      chk("t6_oe_drop", 32'(bus.ram_oe), 32'd0);
      chk("t6_busy", 32'(bus.dl_busy), 32'd0);
      chk("t6_addr", 32'(bus.ram_addr), 32'd0);
      exp_q.delete();
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t6_no_write", 32'(bus.ram_we), 32'd0);
         chk("t6_busy_after", 32'(bus.dl_busy), 32'd0);
      end

      chk("exp_drained", 32'(exp_q.size()), 32'd0);
      chk("ack_drained", 32'(ack_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
